button_event_decoder: RTL and testbench

BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

---
 rtl/button_event_decoder_pkg.sv | 23 ++
 rtl/button_event_decoder_if.sv | 23 ++
 rtl/button_event_decoder_fifo.sv | 46 ++++
 rtl/button_event_decoder.sv | 135 +++++++++++++
 tb/tb_button_event_decoder.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/button_event_decoder_pkg.sv
// Shared types for the button event decoder: event codes, FSM states, helpers.
package btn_pkg;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SHORT  = 2'd1,
    LONG   = 2'd2,
    DOUBLE = 2'd3
  } evt_code_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESSED   = 3'd1,
    LONG_HELD = 3'd2,
    WAIT_GAP  = 3'd3,
    SECOND    = 3'd4
  } btn_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_decoder_if.sv
// Button edge inputs, event queue handshake and status flags of the decoder.
interface button_event_decoder_if;
  import btn_pkg::*;

  logic      btn_rise;
  logic      btn_fall;
  logic      evt_valid;
  logic      evt_ready;
  evt_code_t evt_code;
  logic      held;
  logic      ovf;
  logic      ovf_clr;

  modport master (
    output btn_rise, btn_fall, evt_ready, ovf_clr,
    input  evt_valid, evt_code, held, ovf
  );

  modport slave (
    input  btn_rise, btn_fall, evt_ready, ovf_clr,
    output evt_valid, evt_code, held, ovf
  );
endinterface

// File: rtl/button_event_decoder_fifo.sv
// Event queue; wrap-bit pointers distinguish full from empty.
module btn_evt_fifo
  import btn_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  evt_code_t wdata,
  output evt_code_t rdata,
  output logic      full,
  output logic      empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  evt_code_t   mem [DEPTH];
  logic        do_pop;
  logic        do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are only observed while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/button_event_decoder.sv
// Classifies debounced button presses into SHORT / LONG / DOUBLE events and
// queues them for a ready/valid consumer.
// Optional feature macro: BTN_DOUBLE_PRESS_EN (double-press detection; when
// undefined SHORT is reported on release and DOUBLE is never produced).
module button_event_decoder
  import btn_pkg::*;
#(
  parameter int unsigned LONG_COUNT = 50000000,
  parameter int unsigned GAP_COUNT  = 12500000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  button_event_decoder_if.slave bus
);
  localparam int unsigned CNT_MAX = max_u(LONG_COUNT, GAP_COUNT);
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_COUNT - 1);
`ifdef BTN_DOUBLE_PRESS_EN
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_COUNT - 1);
`endif

  btn_state_t state;
  btn_state_t state_nxt;
  logic [CW-1:0] count;
  logic      armed;
  logic      rise;
  logic      fall;
  logic      push;
  evt_code_t push_code;
  evt_code_t head;
  logic      full;
  logic      empty;
  logic      pop;
  logic      drop;
  logic      ovf;

  // Simultaneous edges cancel; nothing is accepted in the first cycle out of reset.
  assign rise = armed & bus.btn_rise & ~bus.btn_fall;
  assign fall = armed & bus.btn_fall & ~bus.btn_rise;

  // State register and the shared duration counter (restarts on each state change).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      state <= state_nxt;
      count <= (state_nxt != state) ? '0 : count + 1'b1;
    end
  end

  // Next-state and event generation.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_code = NONE;
    unique case (state)
      IDLE: begin
        if (rise) state_nxt = PRESSED;
      end
      PRESSED: begin
        if (fall) begin
`ifdef BTN_DOUBLE_PRESS_EN
          state_nxt = WAIT_GAP;
`else
          push      = 1'b1;
          push_code = SHORT;
          state_nxt = IDLE;
`endif
        end else if (count == LONG_LAST) begin
          push      = 1'b1;
          push_code = LONG;
          state_nxt = LONG_HELD;
        end
      end
      LONG_HELD: begin
        if (fall) state_nxt = IDLE;
      end
`ifdef BTN_DOUBLE_PRESS_EN
      WAIT_GAP: begin
        if (count == GAP_LAST) begin
          push      = 1'b1;
          push_code = SHORT;
          state_nxt = IDLE;
        end else if (rise) begin
          state_nxt = SECOND;
        end
      end
      SECOND: begin
        if (fall) begin
          push      = 1'b1;
          push_code = DOUBLE;
          state_nxt = IDLE;
        end else if (count == LONG_LAST) begin
          push      = 1'b1;
          push_code = DOUBLE;
          state_nxt = LONG_HELD;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign pop  = ~empty & bus.evt_ready;
  assign drop = push & full & ~pop;

  btn_evt_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .wdata(push_code),
    .rdata(head),
    .full (full),
    .empty(empty)
  );

  // Sticky overflow; a drop outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           ovf <= 1'b0;
    else if (drop)        ovf <= 1'b1;
    else if (bus.ovf_clr) ovf <= 1'b0;
  end

  assign bus.evt_valid = ~empty;
  assign bus.evt_code  = empty ? NONE : head;
  assign bus.held      = (state == LONG_HELD);
  assign bus.ovf       = ovf;
endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder (LONG=8, GAP=4, DEPTH=2).
// Honours BTN_DOUBLE_PRESS_EN the same way the design does.
module tb_button_event_decoder;
  import btn_pkg::*;

  localparam int LC = 8;
  localparam int GC = 4;
  localparam int FD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  button_event_decoder_if bus();

  button_event_decoder #(
    .LONG_COUNT(LC),
    .GAP_COUNT (GC),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: press/release timestamps plus a list for the queue.
  int q[$];
  bit m_ovf;
  bit m_held;
  bit skip;
  bit is_second;
  int t_press;
  int t_release;
  int cyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ovf = 0; m_held = 0; skip = 1; is_second = 0;
      t_press = -1; t_release = -1; cyc = 0;
    end else begin
      bit r, f, pop;
      int ev;
      cyc++;
      r = bus.btn_rise && !bus.btn_fall && !skip;
      f = bus.btn_fall && !bus.btn_rise && !skip;
      skip = 0;
      ev = 0;
      if (m_held) begin
        if (f) m_held = 0;
      end else if (t_press >= 0) begin
        if (f) begin
`ifdef BTN_DOUBLE_PRESS_EN
          if (is_second) begin ev = 3; is_second = 0; end
          else t_release = cyc;
`else
          ev = 1;
`endif
          t_press = -1;
        end else if (cyc == t_press + LC) begin
          ev = is_second ? 3 : 2;
          m_held = 1; t_press = -1; is_second = 0;
        end
      end else if (t_release >= 0) begin
        if (cyc == t_release + GC) begin
          ev = 1; t_release = -1;
        end else if (r) begin
          t_press = cyc; is_second = 1; t_release = -1;
        end
      end else if (r) begin
        t_press = cyc;
      end
      pop = (q.size() > 0) && bus.evt_ready;
      if (pop) void'(q.pop_front());
      if (ev != 0 && q.size() >= FD) m_ovf = 1;
      else if (bus.ovf_clr) m_ovf = 0;
      if (ev != 0 && q.size() < FD) q.push_back(ev);
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("evt_valid", int'(bus.evt_valid), int'(q.size() > 0));
      check("evt_code", int'(bus.evt_code), (q.size() > 0) ? q[0] : 0);
      check("held", int'(bus.held), int'(m_held));
      check("ovf", int'(bus.ovf), int'(m_ovf));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rise();
    bus.btn_rise = 1'b1; cycles(1); bus.btn_rise = 1'b0;
  endtask

  task automatic pulse_fall();
    bus.btn_fall = 1'b1; cycles(1); bus.btn_fall = 1'b0;
  endtask

  task automatic short_press();
    pulse_rise(); cycles(1); pulse_fall(); cycles(GC + 4);
  endtask

  // k = number of negedges skipped before evt_valid is seen (limit on timeout).
  task automatic wait_valid(input int limit, output int k);
    k = limit;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.evt_valid) begin k = i; break; end
    end
  endtask

  task automatic drain(input int n, output int cnt, output int c0, output int c1);
    cnt = 0; c0 = 0; c1 = 0;
    bus.evt_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.evt_valid) begin
        if (cnt == 0) c0 = int'(bus.evt_code);
        else if (cnt == 1) c1 = int'(bus.evt_code);
        cnt++;
      end
    end
    @(posedge clk); #1;
    bus.evt_ready = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k, cnt, c0, c1;
    bus.btn_rise = 1'b0; bus.btn_fall = 1'b0;
    bus.evt_ready = 1'b0; bus.ovf_clr = 1'b0;

    #12;
    check("rst_valid", int'(bus.evt_valid), 0);
    check("rst_code", int'(bus.evt_code), 0);
    check("rst_held", int'(bus.held), 0);
    check("rst_ovf", int'(bus.ovf), 0);
    @(negedge clk); rst_n = 1'b1;
    cycles(2);

    // Short press: rise, fall three cycles later. Valid appears in cycle
    // fall+1+GC with gap detection, fall+1 without.
    pulse_rise(); cycles(2); pulse_fall();
    wait_valid(20, k);
`ifdef BTN_DOUBLE_PRESS_EN
    check("short_latency", k, GC);
`else
    check("short_latency", k, 0);
`endif
    check("short_code", int'(bus.evt_code), 1);
    bus.evt_ready = 1'b1; @(posedge clk); #1; bus.evt_ready = 1'b0;
    check("short_popped", int'(bus.evt_valid), 0);

    // Long press: rise at t0, LONG valid at t0+9, release at t0+10.
    cycles(2);
    pulse_rise();
    wait_valid(20, k);
    check("long_latency", k, LC);
    check("long_code", int'(bus.evt_code), 2);
    check("long_held", int'(bus.held), 1);
    cycles(1);
    bus.evt_ready = 1'b1; pulse_fall(); bus.evt_ready = 1'b0;
    check("long_release_held", int'(bus.held), 0);
    cycles(8);
    check("long_no_release_event", int'(bus.evt_valid), 0);

    // Double press: rise, fall +2, rise +4, fall +6.
    pulse_rise(); cycles(1); pulse_fall(); cycles(1);
    pulse_rise(); cycles(1); pulse_fall();
    cycles(GC + 4);
    drain(10, cnt, c0, c1);
`ifdef BTN_DOUBLE_PRESS_EN
    check("double_count", cnt, 1);
    check("double_code", c0, 3);
`else
    check("double_count", cnt, 2);
    check("double_code0", c0, 1);
    check("double_code1", c1, 1);
`endif

    // Simultaneous rise and fall are ignored.
    bus.btn_rise = 1'b1; bus.btn_fall = 1'b1; cycles(1);
    bus.btn_rise = 1'b0; bus.btn_fall = 1'b0;
    cycles(LC + GC + 2);
    check("both_edges_valid", int'(bus.evt_valid), 0);
    check("both_edges_held", int'(bus.held), 0);

    // Overflow: three SHORTs with no consumer.
    repeat (3) short_press();
    check("ovf_set", int'(bus.ovf), 1);
    check("ovf_queue_code", int'(bus.evt_code), 1);
    bus.ovf_clr = 1'b1; cycles(1); bus.ovf_clr = 1'b0;
    check("ovf_cleared", int'(bus.ovf), 0);

    // Drop coinciding with ovf_clr leaves ovf set.
    pulse_rise(); cycles(1);
`ifdef BTN_DOUBLE_PRESS_EN
    pulse_fall();
    bus.ovf_clr = 1'b1; cycles(GC); bus.ovf_clr = 1'b0;
`else
    bus.btn_fall = 1'b1; bus.ovf_clr = 1'b1; cycles(1);
    bus.btn_fall = 1'b0; bus.ovf_clr = 1'b0;
`endif
    check("ovf_drop_beats_clr", int'(bus.ovf), 1);
    bus.ovf_clr = 1'b1; cycles(1); bus.ovf_clr = 1'b0;
    drain(6, cnt, c0, c1);
    check("drain_count", cnt, 2);
    check("drain_code0", c0, 1);
    check("drain_code1", c1, 1);

    // Reset in the middle of a press with two events queued.
    short_press(); short_press();
    pulse_rise(); cycles(2);
    check("pre_reset_valid", int'(bus.evt_valid), 1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_valid", int'(bus.evt_valid), 0);
    check("async_rst_code", int'(bus.evt_code), 0);
    #2 rst_n = 1'b1;
    cycles(2);
    pulse_fall();
    cycles(LC + GC + 2);
    check("post_reset_no_event", int'(bus.evt_valid), 0);
    check("post_reset_held", int'(bus.held), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
